// File: rtl/mem_port_arbiter_if.sv
// Requester, stall/status and RAM-side signals of the memory port arbiter.
// slave = the arbiter; master = the pipeline stages plus the RAM around it.
interface mem_port_arbiter_if #(
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 9
);
  logic                  d_req;
  logic                  d_we;
  logic [31:0]           d_addr;
  logic [DATA_W-1:0]     d_wdata;
  logic                  d_ready;
  logic [DATA_W-1:0]     d_rdata;
  logic                  f_req;
  logic [31:0]           f_addr;
  logic                  f_ready;
  logic [DATA_W-1:0]     f_rdata;
  logic                  dbg_req;
  logic [31:0]           dbg_addr;
  logic                  dbg_ready;
  logic [DATA_W-1:0]     dbg_rdata;
  logic                  stall_f;
  logic                  stall_m;
  logic                  addr_err;
  logic [1:0]            grant_id;
  logic                  mem_en;
  logic                  mem_we;
  logic [DEPTH_LOG2-1:0] mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W-1:0]     mem_rdata;

  modport slave (
    input  d_req, d_we, d_addr, d_wdata, f_req, f_addr, dbg_req, dbg_addr, mem_rdata,
    output d_ready, d_rdata, f_ready, f_rdata, dbg_ready, dbg_rdata,
           stall_f, stall_m, addr_err, grant_id, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output d_req, d_we, d_addr, d_wdata, f_req, f_addr, dbg_req, dbg_addr, mem_rdata,
    input  d_ready, d_rdata, f_ready, f_rdata, dbg_ready, dbg_rdata,
           stall_f, stall_m, addr_err, grant_id, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port RAM between data, fetch and debug; ready comes RAM_LATENCY+2 cycles after
// the request (1 cycle for a range error); losers are held off through stall_f/stall_m until served.
module mem_port_arbiter #(
  parameter int DATA_W       = 32,
  parameter int DEPTH_LOG2   = 9,
  parameter int RAM_LATENCY  = 2,
  parameter int MAX_DATA_RUN = 4
) (
  input logic               CLOCK,
  input logic               RESET,
  mem_port_arbiter_if.slave bus
);
  localparam int LAT_W = $clog2(RAM_LATENCY + 1);
  localparam int RUN_W = $clog2(MAX_DATA_RUN + 1);
  localparam logic [1:0] G_NONE  = 2'd0;
  localparam logic [1:0] G_DATA  = 2'd1;
  localparam logic [1:0] G_FETCH = 2'd2;
  localparam logic [1:0] G_DBG   = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_RESP} state_t;

  state_t                state_q, state_d;
  logic [1:0]            gid_q, gid_d, win;
  logic [LAT_W-1:0]      lat_q, lat_d;
  logic [RUN_W-1:0]      run_q, run_d;
  logic                  we_q, err_q;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic [DATA_W-1:0]     wdata_q, rdata_q;
  logic [31:0]           sel_addr;
  logic                  sel_we, sel_err, grant, capture;
  logic                  in_resp, d_rdy, f_rdy, g_rdy, acc;
  logic                  unused_addr_lsbs;

  // Fetch overrides data once it has watched MAX_DATA_RUN data grants go by.
  always_comb begin
    win = G_NONE;
    if (bus.f_req && run_q == RUN_W'(MAX_DATA_RUN)) win = G_FETCH;
    else if (bus.d_req)                              win = G_DATA;
    else if (bus.f_req)                              win = G_FETCH;
    else if (bus.dbg_req)                            win = G_DBG;
  end

  always_comb begin
    case (win)
      G_DATA:  sel_addr = bus.d_addr;
      G_FETCH: sel_addr = bus.f_addr;
      default: sel_addr = bus.dbg_addr;
    endcase
  end

  assign sel_we           = (win == G_DATA) && bus.d_we;
  assign sel_err          = |sel_addr[31:DEPTH_LOG2+2];
  assign unused_addr_lsbs = ^sel_addr[1:0];

  always_comb begin
    state_d = state_q;
    gid_d   = gid_q;
    lat_d   = lat_q;
    grant   = 1'b0;
    capture = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (win != G_NONE) begin
          grant   = 1'b1;
          gid_d   = win;
          state_d = sel_err ? S_RESP : S_ACCESS;
        end
      end
      S_ACCESS: begin
        lat_d   = LAT_W'(RAM_LATENCY);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        lat_d = lat_q - LAT_W'(1);
        if (lat_q == LAT_W'(1)) begin
          capture = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        gid_d   = G_NONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    run_d = run_q;
    if (!bus.f_req || (grant && win == G_FETCH))
      run_d = '0;
    else if (grant && win == G_DATA && run_q != RUN_W'(MAX_DATA_RUN))
      run_d = run_q + RUN_W'(1);
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      gid_q   <= G_NONE;
      lat_q   <= '0;
      run_q   <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      gid_q   <= gid_d;
      lat_q   <= lat_d;
      run_q   <= run_d;
      // rdata starts at 0 so writes and range errors respond with zero.
      if (grant) begin
        we_q    <= sel_we;
        err_q   <= sel_err;
        idx_q   <= sel_addr[DEPTH_LOG2+1:2];
        wdata_q <= sel_we ? bus.d_wdata : '0;
        rdata_q <= '0;
      end
      if (capture && !we_q) rdata_q <= bus.mem_rdata;
    end
  end

  assign in_resp = (state_q == S_RESP);
  assign d_rdy   = in_resp && (gid_q == G_DATA);
  assign f_rdy   = in_resp && (gid_q == G_FETCH);
  assign g_rdy   = in_resp && (gid_q == G_DBG);
  assign acc     = (state_q == S_ACCESS);

  assign bus.d_ready   = d_rdy;
  assign bus.f_ready   = f_rdy;
  assign bus.dbg_ready = g_rdy;
  assign bus.d_rdata   = d_rdy ? rdata_q : '0;
  assign bus.f_rdata   = f_rdy ? rdata_q : '0;
  assign bus.dbg_rdata = g_rdy ? rdata_q : '0;
  assign bus.addr_err  = in_resp && err_q;
  assign bus.stall_f   = bus.f_req & ~f_rdy;
  assign bus.stall_m   = bus.d_req & ~d_rdy;
  assign bus.grant_id  = gid_q;
  assign bus.mem_en    = acc;
  assign bus.mem_we    = acc && we_q;
  assign bus.mem_addr  = acc ? idx_q : '0;
  assign bus.mem_wdata = acc ? wdata_q : '0;
endmodule
